ace_tape_player: RTL and testbench

Jupiter Ace tape-signal generator: converts a stream of bytes into the square-wave `ear` waveform that the Ace ROM tape loader decodes. It is the transmit end of the cassette interface; the console's `mic` output is the record end. It sits beside the Ace core and drives its `ear` input from a byte source such as a TAP reader or a host bridge. One call produces one tape block: leader tone, sync pulse, then MSB-first data bits.

---
 rtl/ace_tape_pkg.sv | 23 ++
 rtl/tape_halfperiod_timer.sv | 31 +++
 rtl/ace_tape_player.sv | 204 ++++++++++++++++++++
 tb/tb_ace_tape_player.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ace_tape_pkg.sv
// Shared state codes and default timing constants for the Jupiter Ace tape player.
// Benches override the timing parameters on the top module with short values.
package ace_tape_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LEADER = 3'd1;
    localparam logic [2:0] ST_SYNC_H = 3'd2;
    localparam logic [2:0] ST_SYNC_L = 3'd3;
    localparam logic [2:0] ST_DATA_H = 3'd4;
    localparam logic [2:0] ST_DATA_L = 3'd5;
    localparam logic [2:0] ST_WAIT   = 3'd6;
    localparam logic [2:0] ST_TRAIL  = 3'd7;

    localparam int DEF_LEADER_HALF  = 4030;
    localparam int DEF_LEADER_COUNT = 8192;
    localparam int DEF_SYNC_HI      = 1300;
    localparam int DEF_SYNC_LO      = 1420;
    localparam int DEF_ZERO_HALF    = 1590;
    localparam int DEF_ONE_HALF     = 3180;
    localparam int DEF_END_HALF     = 3180;
    localparam int DEF_CW           = 16;

endpackage

// File: rtl/tape_halfperiod_timer.sv
// Half-period down-counter: load a length, get a one-cycle expire on the period's final cycle.
// freeze holds the count and suppresses expire.
module tape_halfperiod_timer
    import ace_tape_pkg::*;
#(
    parameter int CW = DEF_CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          freeze,
    output logic          expire
);

    logic [CW-1:0] count;

    // count holds cycles remaining after the current one
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val - 1'b1;
        end else if (!freeze && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expire = (count == '0) && !freeze;

endmodule

// File: rtl/ace_tape_player.sv
// Jupiter Ace tape-signal generator: bytes in, ear square wave out (leader, sync, MSB-first bits, trailer).
// Define ACE_TAPE_PAUSE_EN to add a `pause` input that freezes the waveform sequence.
module ace_tape_player
    import ace_tape_pkg::*;
#(
    parameter int LEADER_HALF  = DEF_LEADER_HALF,
    parameter int LEADER_COUNT = DEF_LEADER_COUNT,
    parameter int SYNC_HI      = DEF_SYNC_HI,
    parameter int SYNC_LO      = DEF_SYNC_LO,
    parameter int ZERO_HALF    = DEF_ZERO_HALF,
    parameter int ONE_HALF     = DEF_ONE_HALF,
    parameter int END_HALF     = DEF_END_HALF,
    parameter int CW           = DEF_CW
) (
    input  logic       clk,
    input  logic       reset,
`ifdef ACE_TAPE_PAUSE_EN
    input  logic       pause,
`endif
    input  logic       start,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    input  logic       data_last,
    output logic       data_ready,
    output logic       ear,
    output logic       busy,
    output logic       underrun
);

    localparam int LW = $clog2(LEADER_COUNT + 1);

    logic [2:0]    state, state_nx;
    logic          ear_nx, busy_nx, underrun_nx;
    logic [LW-1:0] half_idx, half_idx_nx;
    logic [2:0]    bit_idx, bit_idx_nx;
    logic [7:0]    shifter, shifter_nx;
    logic          shift_last, shift_last_nx;
    logic          held, hold_last;
    logic [7:0]    hold_byte;
    logic          take, consume, want_fetch, freeze, expire, tmr_load;
    logic [CW-1:0] tmr_val;

    function automatic logic [CW-1:0] bit_half(input logic b);
        return b ? CW'(ONE_HALF) : CW'(ZERO_HALF);
    endfunction

`ifdef ACE_TAPE_PAUSE_EN
    assign freeze = pause;
`else
    assign freeze = 1'b0;
`endif

    assign take       = data_valid && !held;
    assign data_ready = !held;

    always_ff @(posedge clk) begin
        if (reset) begin
            held <= 1'b0;
        end else if (take) begin
            held <= 1'b1;
        end else if (consume) begin
            held <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (take) begin
            hold_byte <= data_in;
            hold_last <= data_last;
        end
    end

    // Every transition reloads the timer so the next half starts with no gap cycle
    always_comb begin
        state_nx      = state;
        ear_nx        = ear;
        busy_nx       = busy;
        underrun_nx   = underrun;
        half_idx_nx   = half_idx;
        bit_idx_nx    = bit_idx;
        shifter_nx    = shifter;
        shift_last_nx = shift_last;
        tmr_load      = 1'b0;
        tmr_val       = '0;
        consume       = 1'b0;
        want_fetch    = 1'b0;
        if (!freeze) begin
            case (state)
                ST_IDLE: if (start) begin
                    state_nx    = ST_LEADER;
                    ear_nx      = 1'b1;
                    busy_nx     = 1'b1;
                    underrun_nx = 1'b0;
                    half_idx_nx = '0;
                    tmr_load    = 1'b1;
                    tmr_val     = CW'(LEADER_HALF);
                end
                ST_LEADER: if (expire) begin
                    tmr_load = 1'b1;
                    if (half_idx == LW'(LEADER_COUNT - 1)) begin
                        state_nx = ST_SYNC_H;
                        ear_nx   = 1'b1;
                        tmr_val  = CW'(SYNC_HI);
                    end else begin
                        half_idx_nx = half_idx + 1'b1;
                        ear_nx      = !ear;
                        tmr_val     = CW'(LEADER_HALF);
                    end
                end
                ST_SYNC_H: if (expire) begin
                    state_nx = ST_SYNC_L;
                    ear_nx   = 1'b0;
                    tmr_load = 1'b1;
                    tmr_val  = CW'(SYNC_LO);
                end
                ST_SYNC_L: want_fetch = expire;
                ST_DATA_H: if (expire) begin
                    state_nx = ST_DATA_L;
                    ear_nx   = 1'b0;
                    tmr_load = 1'b1;
                    tmr_val  = bit_half(shifter[7]);
                end
                ST_DATA_L: if (expire) begin
                    if (bit_idx != 3'd0) begin
                        shifter_nx = {shifter[6:0], 1'b0};
                        bit_idx_nx = bit_idx - 1'b1;
                        state_nx   = ST_DATA_H;
                        ear_nx     = 1'b1;
                        tmr_load   = 1'b1;
                        tmr_val    = bit_half(shifter[6]);
                    end else if (shift_last) begin
                        state_nx = ST_TRAIL;
                        ear_nx   = 1'b1;
                        tmr_load = 1'b1;
                        tmr_val  = CW'(END_HALF);
                    end else begin
                        want_fetch = 1'b1;
                    end
                end
                ST_WAIT: want_fetch = held;
                ST_TRAIL: if (expire) begin
                    state_nx = ST_IDLE;
                    ear_nx   = 1'b0;
                    busy_nx  = 1'b0;
                end
                default: begin
                    state_nx = ST_IDLE;
                    ear_nx   = 1'b0;
                    busy_nx  = 1'b0;
                end
            endcase
            if (want_fetch) begin
                if (held) begin
                    consume       = 1'b1;
                    shifter_nx    = hold_byte;
                    shift_last_nx = hold_last;
                    bit_idx_nx    = 3'd7;
                    state_nx      = ST_DATA_H;
                    ear_nx        = 1'b1;
                    tmr_load      = 1'b1;
                    tmr_val       = bit_half(hold_byte[7]);
                end else begin
                    underrun_nx = 1'b1;
                    state_nx    = ST_WAIT;
                    ear_nx      = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            ear        <= 1'b0;
            busy       <= 1'b0;
            underrun   <= 1'b0;
            half_idx   <= '0;
            bit_idx    <= '0;
            shift_last <= 1'b0;
        end else begin
            state      <= state_nx;
            ear        <= ear_nx;
            busy       <= busy_nx;
            underrun   <= underrun_nx;
            half_idx   <= half_idx_nx;
            bit_idx    <= bit_idx_nx;
            shift_last <= shift_last_nx;
        end
    end

    always_ff @(posedge clk) begin
        shifter <= shifter_nx;
    end

    tape_halfperiod_timer #(.CW(CW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .freeze   (freeze),
        .expire   (expire)
    );

endmodule

// File: tb/tb_ace_tape_player.sv
// Bench for ace_tape_player: random and directed blocks compared cycle by cycle with a segment-list waveform model.
// Pause coverage is compiled in when ACE_TAPE_PAUSE_EN is defined.
module tb_ace_tape_player;

    localparam int LH = 10, LC = 4, SH = 3, SL = 4, ZH = 2, OH = 5, EH = 6, CW = 16;

    logic       clk = 1'b0;
    logic       reset, start, data_valid, data_last;
    logic [7:0] data_in;
    logic       data_ready, ear, busy, underrun;
`ifdef ACE_TAPE_PAUSE_EN
    logic       pause;
`endif

    int checks = 0;
    int passed = 0;

    logic [7:0] blk[$];
    bit         exp_q[$];

    always #5 clk = ~clk;

    ace_tape_player #(
        .LEADER_HALF(LH), .LEADER_COUNT(LC), .SYNC_HI(SH), .SYNC_LO(SL),
        .ZERO_HALF(ZH), .ONE_HALF(OH), .END_HALF(EH), .CW(CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef ACE_TAPE_PAUSE_EN
        .pause      (pause),
`endif
        .start      (start),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_last  (data_last),
        .data_ready (data_ready),
        .ear        (ear),
        .busy       (busy),
        .underrun   (underrun)
    );

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, act, exp);
    endtask

    task automatic push(input bit lvl, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(lvl);
    endtask

    // Build the expected waveform for blk, then drive and compare every cycle.
    // gap_idx: byte withheld for gap_len cycles past its fetch point (-1 = none).
    task automatic run_block(input int gap_idx, input int gap_len, input int extra, input int pause_at);
        int rel[$];
        int ptr, und_from, len, es, hl;
        exp_q.delete();
        und_from = -1;
        for (int h = 0; h < LC; h++) push(h % 2 == 0, LH);
        push(1'b1, SH);
        push(1'b0, SL);
        for (int i = 0; i < blk.size(); i++) begin
            if (i == gap_idx) begin
                und_from = exp_q.size() + 1;
                rel.push_back(exp_q.size() + gap_len);
                push(1'b0, gap_len + 1);
            end else begin
                rel.push_back(0);
            end
            for (int b = 7; b >= 0; b--) begin
                hl = blk[i][b] ? OH : ZH;
                push(1'b1, hl);
                push(1'b0, hl);
            end
        end
        push(1'b1, EH);
        if (pause_at > 0) begin
            for (int i = 0; i < 7; i++) exp_q.insert(pause_at - 1, exp_q[pause_at - 1]);
        end
        len = exp_q.size();
        es  = extra ? int'($urandom_range(1, len - 1)) : -1;

        @(posedge clk); #1;
        check("ready_before_preload", data_ready, 1);
        data_in    = blk[0];
        data_last  = (blk.size() == 1);
        data_valid = 1'b1;
        @(posedge clk); #1;
        data_valid = 1'b0;
        start      = 1'b1;
        ptr        = 1;
        for (int k = 0; k <= len + 3; k++) begin
            if (k > 0) start = (k == es);
`ifdef ACE_TAPE_PAUSE_EN
            pause = (pause_at > 0 && k >= pause_at && k < pause_at + 7);
`endif
            if (ptr < blk.size() && k >= rel[ptr]) begin
                data_valid = 1'b1;
                data_in    = blk[ptr];
                data_last  = (ptr == blk.size() - 1);
            end else begin
                data_valid = 1'b0;
            end
            @(negedge clk);
            if (k >= 1) begin
                check("ear", ear, (k <= len) ? int'(exp_q[k-1]) : 0);
                check("busy", busy, (k <= len) ? 1 : 0);
                check("underrun", underrun, (und_from > 0 && k >= und_from) ? 1 : 0);
            end
            if (data_valid && data_ready) ptr++;
            @(posedge clk); #1;
        end
        start      = 1'b0;
        data_valid = 1'b0;
        data_last  = 1'b0;
`ifdef ACE_TAPE_PAUSE_EN
        pause = 1'b0;
`endif
        check("bytes_taken", ptr, blk.size());
    endtask

    initial begin
        int n;
        reset      = 1'b1;
        start      = 1'b0;
        data_valid = 1'b0;
        data_last  = 1'b0;
        data_in    = 8'h00;
`ifdef ACE_TAPE_PAUSE_EN
        pause = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ear", ear, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", data_ready, 1);
        check("rst_underrun", underrun, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        blk = '{8'hA5};
        run_block(-1, 0, 0, 0);

        blk = '{8'h00, 8'hFF};
        run_block(-1, 0, 0, 0);

        blk = '{8'hA5, 8'h3C};
        run_block(1, 20, 0, 0);

        // Sticky underrun must be cleared by reset while idle
        @(negedge clk);
        check("underrun_sticky", underrun, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("underrun_after_rst", underrun, 0);

        blk = '{8'hA5};
        run_block(-1, 0, 1, 0);

        // Reset in the middle of the leader with a byte still held
        @(posedge clk); #1;
        data_in = 8'h3C; data_last = 1'b0; data_valid = 1'b1;
        @(posedge clk); #1;
        data_valid = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        check("mid_leader_ear", ear, 1);
        check("mid_leader_busy", busy, 1);
        check("mid_leader_ready", data_ready, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ear", ear, 0);
        check("post_rst_busy", busy, 0);
        check("post_rst_ready", data_ready, 1);
        check("post_rst_underrun", underrun, 0);

        for (int r = 0; r < 5; r++) begin
            n = $urandom_range(1, 3);
            blk.delete();
            for (int i = 0; i < n; i++) blk.push_back(8'($urandom));
            if (n > 1 && $urandom_range(0, 1) == 1)
                run_block($urandom_range(1, n - 1), $urandom_range(0, 30), 0, 0);
            else
                run_block(-1, 0, $urandom_range(0, 1), 0);
        end

`ifdef ACE_TAPE_PAUSE_EN
        // Cycle 50 falls inside the first ONE_HALF high half of 0xA5
        blk = '{8'hA5};
        run_block(-1, 0, 0, 50);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
